mips_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the Lab4 MIPS ALU datapath. It accepts one 32-bit instruction word per transaction over a valid/ready handshake and decodes opcode/funct into the datapath control fields (alu_op, alu_src2, rd_src). It then steps through execute and writeback, pulsing writeenable once per legal instruction and except once per illegal one. It sits between the instruction source and the register file/ALU, and keeps retire and exception counters.

---
 rtl/mips_multicycle_ctrl.sv | 111 +++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control sequencer for the Lab4 MIPS ALU datapath.
// Accepts one instruction per valid/ready handshake, decodes it, and steps FETCH->DECODE->EXEC->WB/EXCEPT.
module mips_multicycle_ctrl #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        inst,
    input  logic               inst_valid,
    output logic               inst_ready,
    output logic [2:0]         alu_op,
    output logic [1:0]         alu_src2,
    output logic               rd_src,
    output logic               writeenable,
    output logic               except,
    output logic               busy,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] retired_count,
    output logic [COUNT_W-1:0] except_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        EXCEPT = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] ir;
    logic [2:0]  dec_op;
    logic [1:0]  dec_src2;
    logic        dec_rd;
    logic        dec_legal;
    logic        ir_unused;

    // Register-number and immediate fields belong to the datapath, not the sequencer.
    assign ir_unused = ^ir[25:6];

    always_comb begin
        dec_op    = 3'd0;
        dec_src2  = 2'd0;
        dec_rd    = 1'b0;
        dec_legal = 1'b0;
        case (ir[31:26])
            6'h00: begin
                case (ir[5:0])
                    6'h20: begin dec_op = 3'd2; dec_legal = 1'b1; end
                    6'h22: begin dec_op = 3'd3; dec_legal = 1'b1; end
                    6'h24: begin dec_op = 3'd4; dec_legal = 1'b1; end
                    6'h25: begin dec_op = 3'd5; dec_legal = 1'b1; end
                    6'h26: begin dec_op = 3'd7; dec_legal = 1'b1; end
                    6'h27: begin dec_op = 3'd6; dec_legal = 1'b1; end
                    default: ;
                endcase
            end
            6'h08: begin dec_op = 3'd2; dec_src2 = 2'd1; dec_rd = 1'b1; dec_legal = 1'b1; end
            6'h0c: begin dec_op = 3'd4; dec_src2 = 2'd2; dec_rd = 1'b1; dec_legal = 1'b1; end
            6'h0d: begin dec_op = 3'd5; dec_src2 = 2'd2; dec_rd = 1'b1; dec_legal = 1'b1; end
            6'h0e: begin dec_op = 3'd7; dec_src2 = 2'd2; dec_rd = 1'b1; dec_legal = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (inst_valid) state_d = DECODE;
            DECODE:  state_d = dec_legal ? EXEC : EXCEPT;
            EXEC:    state_d = WB;
            WB:      state_d = FETCH;
            EXCEPT:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FETCH;
            ir            <= '0;
            alu_op        <= '0;
            alu_src2      <= '0;
            rd_src        <= 1'b0;
            retired_count <= '0;
            except_count  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && inst_valid)
                ir <= inst;
            // Illegal words decode to all-zero fields, so a single load covers both outcomes.
            if (state_q == DECODE) begin
                alu_op   <= dec_op;
                alu_src2 <= dec_src2;
                rd_src   <= dec_rd;
            end
            if (state_q == WB)
                retired_count <= retired_count + COUNT_W'(1);
            if (state_q == EXCEPT)
                except_count <= except_count + COUNT_W'(1);
        end
    end

    assign inst_ready  = (state_q == FETCH);
    assign busy        = (state_q != FETCH);
    assign writeenable = (state_q == WB);
    assign except      = (state_q == EXCEPT);
    assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl: decode table, timing, exceptions, reset and counter wrap.
module tb_mips_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src2;
    logic        rd_src;
    logic        writeenable;
    logic        except;
    logic        busy;
    logic [2:0]  state;
    logic [15:0] retired_count;
    logic [15:0] except_count;

    logic [31:0] inst2 = '0;
    logic        inst_valid2 = 1'b0;
    logic        inst_ready2;
    logic [2:0]  alu_op2;
    logic [1:0]  alu_src2_2;
    logic        rd_src2;
    logic        writeenable2;
    logic        except2;
    logic        busy2;
    logic [2:0]  state2;
    logic [1:0]  retired_count2;
    logic [1:0]  except_count2;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned exp_ret = 0;

    mips_multicycle_ctrl #(.COUNT_W(16)) dut (
        .clock(clock), .reset(reset), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .alu_op(alu_op), .alu_src2(alu_src2), .rd_src(rd_src),
        .writeenable(writeenable), .except(except), .busy(busy), .state(state),
        .retired_count(retired_count), .except_count(except_count)
    );

    mips_multicycle_ctrl #(.COUNT_W(2)) dut_w2 (
        .clock(clock), .reset(reset), .inst(inst2), .inst_valid(inst_valid2),
        .inst_ready(inst_ready2), .alu_op(alu_op2), .alu_src2(alu_src2_2), .rd_src(rd_src2),
        .writeenable(writeenable2), .except(except2), .busy(busy2), .state(state2),
        .retired_count(retired_count2), .except_count(except_count2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] funct);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op);
        return {op, 5'd1, 5'd2, 16'h8001};
    endfunction

    // Starts in FETCH; leaves inst_valid high so a following call is accepted 4 cycles after this one.
    task automatic exec_legal(input string tag, input logic [31:0] w,
                              input int unsigned op, input int unsigned src2, input int unsigned rd);
        inst = w;
        inst_valid = 1'b1;
        step();
        check({tag, " decode state"}, state, 1);
        check({tag, " decode ready"}, inst_ready, 0);
        inst = ~w;
        step();
        check({tag, " exec state"}, state, 2);
        check({tag, " exec alu_op"}, alu_op, op);
        check({tag, " exec alu_src2"}, alu_src2, src2);
        check({tag, " exec rd_src"}, rd_src, rd);
        check({tag, " exec we"}, writeenable, 0);
        step();
        check({tag, " wb state"}, state, 3);
        check({tag, " wb we"}, writeenable, 1);
        check({tag, " wb except"}, except, 0);
        check({tag, " wb alu_op"}, alu_op, op);
        step();
        exp_ret++;
        check({tag, " fetch ready"}, inst_ready, 1);
        check({tag, " fetch we"}, writeenable, 0);
        check({tag, " retired"}, retired_count, exp_ret);
        check({tag, " held alu_op"}, alu_op, op);
    endtask

    task automatic exec_illegal(input string tag, input logic [31:0] w, input int unsigned exp_exc);
        inst = w;
        inst_valid = 1'b1;
        step();
        check({tag, " decode state"}, state, 1);
        step();
        check({tag, " except state"}, state, 4);
        check({tag, " except pulse"}, except, 1);
        check({tag, " except we"}, writeenable, 0);
        check({tag, " except alu_op"}, alu_op, 0);
        step();
        check({tag, " fetch state"}, state, 0);
        check({tag, " except low"}, except, 0);
        check({tag, " except_count"}, except_count, exp_exc);
        check({tag, " retired hold"}, retired_count, exp_ret);
    endtask

    int unsigned w2_seq [5] = '{1, 2, 3, 0, 1};

    initial begin
        step();
        step();
        reset = 1'b0;
        check("rst state", state, 0);
        check("rst alu_op", alu_op, 0);
        check("rst alu_src2", alu_src2, 0);
        check("rst rd_src", rd_src, 0);
        check("rst retired", retired_count, 0);
        check("rst except_count", except_count, 0);

        for (int i = 0; i < 5; i++) begin
            step();
            check("idle state", state, 0);
            check("idle ready", inst_ready, 1);
            check("idle busy", busy, 0);
            check("idle we", writeenable, 0);
            check("idle except", except, 0);
            check("idle alu_op", alu_op, 0);
        end

        exec_legal("add", r_type(6'h20), 2, 0, 0);
        inst_valid = 1'b0;
        step();
        check("add idle state", state, 0);

        exec_legal("addi", i_type(6'h08), 2, 1, 1);
        exec_legal("andi", i_type(6'h0c), 4, 2, 1);
        inst_valid = 1'b0;
        step();
        check("b2b retired", retired_count, 3);

        exec_illegal("ill funct", r_type(6'h21), 1);
        exec_illegal("ill op", i_type(6'h23), 2);
        exec_legal("xor", r_type(6'h26), 7, 0, 0);
        exec_legal("nor", r_type(6'h27), 6, 0, 0);
        exec_legal("or", r_type(6'h25), 5, 0, 0);
        exec_legal("and", r_type(6'h24), 4, 0, 0);
        exec_legal("ori", i_type(6'h0d), 5, 2, 1);
        exec_legal("xori", i_type(6'h0e), 7, 2, 1);
        inst_valid = 1'b0;
        step();
        check("mix except_count", except_count, 2);

        inst = r_type(6'h22);
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        step();
        check("sub exec state", state, 2);
        check("sub exec alu_op", alu_op, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst mid state", state, 0);
        check("rst mid alu_op", alu_op, 0);
        check("rst mid we", writeenable, 0);
        check("rst mid retired", retired_count, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post rst we", writeenable, 0);
            check("post rst state", state, 0);
        end
        check("post rst retired", retired_count, 0);

        for (int i = 0; i < 5; i++) begin
            inst2 = r_type(6'h25);
            inst_valid2 = 1'b1;
            step();
            inst_valid2 = 1'b0;
            step();
            check("w2 alu_op", alu_op2, 5);
            step();
            check("w2 we", writeenable2, 1);
            step();
            check("w2 retired", retired_count2, w2_seq[i]);
        end
        check("w2 except_count", except_count2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
